gerador_pwm_multicanal: RTL and testbench
=========================================

# gerador_pwm_multicanal

Multi-channel PWM generator; parametrised successor of the single-output fixed-ratio oscillator. Each of `CANAIS` channels owns a free-running period counter with a programmable period and duty compare. Each channel drives a registered PWM output and a period-start strobe. It sits between the control/register logic, which writes period/duty over a simple strobe interface, and the pins or downstream drivers.

## Interface
- `LARGURA`, 8: width of counters, period and duty values.
- `CANAIS`, 4: number of independent channels (≥1).
- `PERIODO_PADRAO`, 10: period loaded at reset, in clocks.
- `RAZAO_PADRAO`, 5: duty (high-time clocks) loaded at reset.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears the block immediately, independent of `clock`.
- `habilitar_contagem`  in  1  global enable.
- `habilitar_canal`  in  CANAIS  per-channel enable.
- `escrever`  in  1  write strobe, sampled each edge.
- `canal_escrita`  in  max(1,$clog2(CANAIS))  target channel of the write.
- `periodo_in`  in  LARGURA  new period.
- `razao_in`  in  LARGURA  new duty.
- `pulso`  out  CANAIS  PWM outputs, registered.
- `inicio_periodo`  out  CANAIS  one-clock strobe marking each period start, registered.
- `escrita_pendente`  out  CANAIS  shadow write not yet applied.

## Operation
- Channel c is active when `habilitar_contagem & habilitar_canal[c]`.
- **Inactive channel, each edge:**
  - `contador` = 0, `pulso` = 0, `inicio_periodo` = 0.
  - Any pending shadow value is copied to the active registers; pending is cleared.
- **Active channel, each edge:**
  - `pulso` <= (`contador` < `razao_ativa`) && (`periodo_ativo` != 0).
  - `inicio_periodo` <= (`contador` == 0) && (`periodo_ativo` != 0).
  - `contador` <= (`contador` >= `periodo_ativo`-1) ? 0 : `contador`+1.
- **Write:** when `escrever` = 1 and `canal_escrita` < CANAIS, (`periodo_in`, `razao_in`) go to channel `canal_escrita`. Writes to an index ≥ CANAIS are ignored.
- **Arithmetic:**
  - All comparisons are unsigned, LARGURA bits.
  - `periodo_ativo` = 0: channel is held with `contador` = 0 and outputs 0.
  - `razao_ativa` = 0: `pulso` is held at 0.
  - `razao_ativa` ≥ `periodo_ativo`: `pulso` is held at 1 (100%).
- **Reset:** `pulso`, `inicio_periodo`, `escrita_pendente` = 0. All counters = 0. Active and shadow registers = PADRAO values.

## Timing
- On the first edge with the channel active, `pulso` rises (if `razao_ativa` > 0) together with an `inicio_periodo` strobe.
- The waveform is then exactly `razao_ativa` high clocks followed by `periodo_ativo`-`razao_ativa` low clocks, repeating.
- Deactivation: outputs are 0 after the next edge. Reactivation always starts a fresh period.
- Channels are fully independent; a write to one channel never perturbs the others.
- Reset assertion takes effect combinationally-async. The first active edge after deassertion behaves as the first active edge above.

## Configuration
- `PWM_REGISTRO_SOMBRA_EN` **defined** (double-buffered writes):
  - A write lands in the shadow registers and sets `escrita_pendente[c]`.
  - On the wrap edge (`contador` >= `periodo_ativo`-1), shadow is copied to active and pending clears. The next period uses the new values; no glitched period ever occurs.
  - A write on the same edge as a wrap stays pending until the following wrap.
  - Back-to-back writes: the last one wins.
- `PWM_REGISTRO_SOMBRA_EN` **undefined** (direct writes):
  - A write updates the active registers at that edge; `escrita_pendente` is tied to 0.
  - If the new period ≤ `contador`, the counter wraps to 0 on the next edge via the ≥ comparison.

## Structure
- Shared package `pacote_pwm`: default constants (PERIODO_PADRAO, RAZAO_PADRAO, LARGURA default) and the channel-index width function.
- Sub-module `canal_pwm` holds one channel: counter, active/shadow registers, output flops.
- The top level decodes the write and instantiates `canal_pwm` CANAIS times with a generate loop.

## Test plan
(LARGURA=8, CANAIS=4, PADRAO 10/5, macro defined unless stated.)
- **Default run:** reset, then enable channel 0 → `pulso[0]` is 5 high / 5 low repeating; `inicio_periodo[0]` fires every 10 clocks, aligned with the rising `pulso`; other channels stay 0.
- **Shadow update:** write periodo=4, razao=1 to channel 2 at `contador`=3 → the current 10-clock period finishes 5/5 with `escrita_pendente[2]`=1; then 1 high / 3 low with pending=0. With the macro undefined, the change applies at the next edge instead.
- **Duty boundaries:** razao=0 → `pulso` constant 0. razao=12, periodo=10 → constant 1. periodo=0 → outputs 0 and no `inicio_periodo`.
- **Global disable:** drop `habilitar_contagem` at mid-period → all `pulso` 0 at the next edge. Re-enable → all enabled channels restart in phase.
- **Async reset:** assert `reset` between edges mid-operation → outputs and pending clear without a clock edge. After release, channels return to 10/5.
- **Write edge cases:**
  - Write on the wrap edge → applied at the following wrap.
  - With CANAIS=3, a write to index 3 is ignored.

Source files
------------

// File: rtl/gerador_pwm_multicanal_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
// Imported by canal_pwm and gerador_pwm_multicanal.
package pacote_pwm;

  localparam int PADRAO_LARGURA = 8;
  localparam int PADRAO_PERIODO = 10;
  localparam int PADRAO_RAZAO   = 5;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int largura_indice(input int canais);
    return (canais > 1) ? $clog2(canais) : 1;
  endfunction

endpackage

// File: rtl/gerador_pwm_multicanal_canal.sv
// canal_pwm: one PWM channel (period counter, active/shadow settings, output flops).
// PWM_REGISTRO_SOMBRA_EN selects double-buffered writes; otherwise writes hit the active settings.
module canal_pwm
  import pacote_pwm::*;
#(
  parameter int LARGURA        = PADRAO_LARGURA,
  parameter int PERIODO_PADRAO = PADRAO_PERIODO,
  parameter int RAZAO_PADRAO   = PADRAO_RAZAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ativo_i,
  input  logic               escrever_i,
  input  logic [LARGURA-1:0] periodo_i,
  input  logic [LARGURA-1:0] razao_i,
  output logic               pulso_o,
  output logic               inicio_periodo_o,
  output logic               escrita_pendente_o
);

  localparam logic [LARGURA-1:0] PERIODO_RESET = LARGURA'(PERIODO_PADRAO);
  localparam logic [LARGURA-1:0] RAZAO_RESET   = LARGURA'(RAZAO_PADRAO);

  logic [LARGURA-1:0] contador_q, contador_d;
  logic [LARGURA-1:0] periodo_q, periodo_d;
  logic [LARGURA-1:0] razao_q, razao_d;
  logic               pulso_q, pulso_d;
  logic               inicio_q, inicio_d;
  logic               periodo_nulo;
  logic               fim_periodo;

`ifdef PWM_REGISTRO_SOMBRA_EN
  logic [LARGURA-1:0] sombra_periodo_q, sombra_periodo_d;
  logic [LARGURA-1:0] sombra_razao_q, sombra_razao_d;
  logic               pendente_q, pendente_d;
`endif

  // A zero period counts as wrapping every edge so a pending shadow write can still land.
  assign periodo_nulo = (periodo_q == '0);
  assign fim_periodo  = periodo_nulo || (contador_q >= periodo_q - LARGURA'(1));

  always_comb begin
    contador_d = '0;
    pulso_d    = 1'b0;
    inicio_d   = 1'b0;
    periodo_d  = periodo_q;
    razao_d    = razao_q;
`ifdef PWM_REGISTRO_SOMBRA_EN
    sombra_periodo_d = sombra_periodo_q;
    sombra_razao_d   = sombra_razao_q;
    pendente_d       = pendente_q;
    if (!ativo_i || fim_periodo) begin
      periodo_d  = sombra_periodo_q;
      razao_d    = sombra_razao_q;
      pendente_d = 1'b0;
    end
    // A write coinciding with a wrap is held for the following wrap.
    if (escrever_i) begin
      sombra_periodo_d = periodo_i;
      sombra_razao_d   = razao_i;
      pendente_d       = 1'b1;
    end
`else
    if (escrever_i) begin
      periodo_d = periodo_i;
      razao_d   = razao_i;
    end
`endif
    if (ativo_i) begin
      pulso_d    = (contador_q < razao_q) && !periodo_nulo;
      inicio_d   = (contador_q == '0) && !periodo_nulo;
      contador_d = fim_periodo ? '0 : contador_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_q <= '0;
      periodo_q  <= PERIODO_RESET;
      razao_q    <= RAZAO_RESET;
      pulso_q    <= 1'b0;
      inicio_q   <= 1'b0;
`ifdef PWM_REGISTRO_SOMBRA_EN
      sombra_periodo_q <= PERIODO_RESET;
      sombra_razao_q   <= RAZAO_RESET;
      pendente_q       <= 1'b0;
`endif
    end else begin
      contador_q <= contador_d;
      periodo_q  <= periodo_d;
      razao_q    <= razao_d;
      pulso_q    <= pulso_d;
      inicio_q   <= inicio_d;
`ifdef PWM_REGISTRO_SOMBRA_EN
      sombra_periodo_q <= sombra_periodo_d;
      sombra_razao_q   <= sombra_razao_d;
      pendente_q       <= pendente_d;
`endif
    end
  end

  assign pulso_o          = pulso_q;
  assign inicio_periodo_o = inicio_q;
`ifdef PWM_REGISTRO_SOMBRA_EN
  assign escrita_pendente_o = pendente_q;
`else
  assign escrita_pendente_o = 1'b0;
`endif

endmodule

// File: rtl/gerador_pwm_multicanal.sv
// Multi-channel PWM generator: write decode plus CANAIS independent canal_pwm instances.
// Define PWM_REGISTRO_SOMBRA_EN for double-buffered (wrap-synchronised) period/duty writes.
module gerador_pwm_multicanal
  import pacote_pwm::*;
#(
  parameter int LARGURA        = PADRAO_LARGURA,
  parameter int CANAIS         = 4,
  parameter int PERIODO_PADRAO = PADRAO_PERIODO,
  parameter int RAZAO_PADRAO   = PADRAO_RAZAO
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                habilitar_contagem,
  input  logic [CANAIS-1:0]                   habilitar_canal,
  input  logic                                escrever,
  input  logic [largura_indice(CANAIS)-1:0]   canal_escrita,
  input  logic [LARGURA-1:0]                  periodo_in,
  input  logic [LARGURA-1:0]                  razao_in,
  output logic [CANAIS-1:0]                   pulso,
  output logic [CANAIS-1:0]                   inicio_periodo,
  output logic [CANAIS-1:0]                   escrita_pendente
);

  localparam int LARGURA_IDX = largura_indice(CANAIS);

  for (genvar gi = 0; gi < CANAIS; gi++) begin : g_canal
    logic sel_escrita;
    logic ativo;

    // Indices >= CANAIS match no instance, so such writes are dropped.
    assign sel_escrita = escrever && (canal_escrita == LARGURA_IDX'(gi));
    assign ativo       = habilitar_contagem && habilitar_canal[gi];

    canal_pwm #(
      .LARGURA       (LARGURA),
      .PERIODO_PADRAO(PERIODO_PADRAO),
      .RAZAO_PADRAO  (RAZAO_PADRAO)
    ) u_canal (
      .clock             (clock),
      .reset             (reset),
      .ativo_i           (ativo),
      .escrever_i        (sel_escrita),
      .periodo_i         (periodo_in),
      .razao_i           (razao_in),
      .pulso_o           (pulso[gi]),
      .inicio_periodo_o  (inicio_periodo[gi]),
      .escrita_pendente_o(escrita_pendente[gi])
    );
  end

endmodule

// File: tb/tb_gerador_pwm_multicanal.sv
// Self-checking bench for gerador_pwm_multicanal against a period-level behavioural model.
// Follows PWM_REGISTRO_SOMBRA_EN when it is defined for the build.
module tb_gerador_pwm_multicanal;

  localparam int NC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          habilitar_contagem;
  logic [NC-1:0] habilitar_canal;
  logic          escrever;
  logic [1:0]    canal_escrita;
  logic [7:0]    periodo_in, razao_in;
  logic [NC-1:0] pulso, inicio_periodo, escrita_pendente;

  logic          esc3;
  logic [1:0]    canal3;
  logic [7:0]    per3, raz3;
  logic [2:0]    pulso3, inicio3, pend3;

  int checks = 0;
  int errors = 0;

  // Model: position inside the current period plus active/shadow settings.
  int            m_pos[NC], m_per[NC], m_raz[NC], m_sper[NC], m_sraz[NC];
  logic [NC-1:0] exp_pulso, exp_inicio, exp_pend;

  always #5 clock = ~clock;

  gerador_pwm_multicanal dut (
    .clock(clock), .reset(reset), .habilitar_contagem(habilitar_contagem),
    .habilitar_canal(habilitar_canal), .escrever(escrever), .canal_escrita(canal_escrita),
    .periodo_in(periodo_in), .razao_in(razao_in), .pulso(pulso),
    .inicio_periodo(inicio_periodo), .escrita_pendente(escrita_pendente)
  );

  gerador_pwm_multicanal #(.CANAIS(3)) dut3 (
    .clock(clock), .reset(reset), .habilitar_contagem(habilitar_contagem),
    .habilitar_canal(habilitar_canal[2:0]), .escrever(esc3), .canal_escrita(canal3),
    .periodo_in(per3), .razao_in(raz3), .pulso(pulso3),
    .inicio_periodo(inicio3), .escrita_pendente(pend3)
  );

  task automatic modelo_reset();
    for (int c = 0; c < NC; c++) begin
      m_pos[c] = 0; m_per[c] = 10; m_raz[c] = 5; m_sper[c] = 10; m_sraz[c] = 5;
    end
    exp_pulso = '0; exp_inicio = '0; exp_pend = '0;
  endtask

  // One clock of the reference: emit this period position, then advance / start a new period.
  task automatic passo_modelo();
    for (int c = 0; c < NC; c++) begin
      bit ativo;
      bit wr;
      ativo = habilitar_contagem && habilitar_canal[c];
      wr    = escrever && (int'(canal_escrita) == c);
      if (!ativo) begin
        exp_pulso[c] = 1'b0; exp_inicio[c] = 1'b0; m_pos[c] = 0;
`ifdef PWM_REGISTRO_SOMBRA_EN
        m_per[c] = m_sper[c]; m_raz[c] = m_sraz[c]; exp_pend[c] = 1'b0;
`endif
      end else begin
        exp_pulso[c]  = (m_per[c] != 0) && (m_pos[c] < m_raz[c]);
        exp_inicio[c] = (m_per[c] != 0) && (m_pos[c] == 0);
        if (m_pos[c] + 1 >= m_per[c]) begin
          m_pos[c] = 0;
`ifdef PWM_REGISTRO_SOMBRA_EN
          m_per[c] = m_sper[c]; m_raz[c] = m_sraz[c]; exp_pend[c] = 1'b0;
`endif
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
      end
      if (wr) begin
`ifdef PWM_REGISTRO_SOMBRA_EN
        m_sper[c] = int'(periodo_in); m_sraz[c] = int'(razao_in); exp_pend[c] = 1'b1;
`else
        m_per[c] = int'(periodo_in); m_raz[c] = int'(razao_in);
`endif
      end
    end
  endtask

  task automatic avanca();
    @(posedge clock);
    if (reset) modelo_reset();
    else passo_modelo();
    #1;
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    avanca();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pulso, inicio_periodo, escrita_pendente} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async got %b required 0", {pulso, inicio_periodo, escrita_pendente});
    end
    avanca();
    checks++;
    if ({pulso, inicio_periodo, escrita_pendente, pulso3, pend3} !== 18'h0) begin
      errors++;
      $display("FAIL reset_edge got %b required 0", {pulso, inicio_periodo, escrita_pendente, pulso3, pend3});
    end
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_default();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b0001;
    for (int k = 0; k < 25; k++) begin
      avanca();
      checks++;
      if ({pulso, inicio_periodo, escrita_pendente} !== {exp_pulso, exp_inicio, exp_pend}) begin
        errors++;
        $display("FAIL default_model k=%0d got %b/%b/%b required %b/%b/%b", k,
                 pulso, inicio_periodo, escrita_pendente, exp_pulso, exp_inicio, exp_pend);
      end
      checks++;
      if (pulso !== {3'b000, (k % 10) < 5} || inicio_periodo !== {3'b000, (k % 10) == 0}) begin
        errors++;
        $display("FAIL default_wave k=%0d got pulso=%b inicio=%b required pulso[0]=%0d inicio[0]=%0d",
                 k, pulso, inicio_periodo, (k % 10) < 5, (k % 10) == 0);
      end
    end
  endtask

  task automatic test_shadow();
    aplica_reset();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b0100;
    for (int k = 0; k < 20 && m_pos[2] != 3; k++) avanca();
    escrever = 1'b1; canal_escrita = 2'd2; periodo_in = 8'd4; razao_in = 8'd1;
    avanca();
    escrever = 1'b0;
    $display("write ch2 periodo=4 razao=1");
    checks++;
`ifdef PWM_REGISTRO_SOMBRA_EN
    if (escrita_pendente !== 4'b0100) begin
`else
    if (escrita_pendente !== 4'b0000) begin
`endif
      errors++;
      $display("FAIL shadow_pending got %b", escrita_pendente);
    end
    for (int k = 0; k < 20; k++) begin
      avanca();
      checks++;
      if ({pulso, inicio_periodo, escrita_pendente} !== {exp_pulso, exp_inicio, exp_pend}) begin
        errors++;
        $display("FAIL shadow_model k=%0d got %b/%b/%b required %b/%b/%b", k,
                 pulso, inicio_periodo, escrita_pendente, exp_pulso, exp_inicio, exp_pend);
      end
    end
  endtask

  task automatic test_boundaries();
    aplica_reset();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b0000;
    escrever = 1'b1;
    canal_escrita = 2'd1; periodo_in = 8'd10; razao_in = 8'd0;  avanca();
    canal_escrita = 2'd2; periodo_in = 8'd10; razao_in = 8'd12; avanca();
    canal_escrita = 2'd3; periodo_in = 8'd0;  razao_in = 8'd5;  avanca();
    escrever = 1'b0;
    avanca();
    habilitar_canal = 4'b1110;
    for (int k = 0; k < 25; k++) begin
      avanca();
      checks++;
      if ({pulso, inicio_periodo, escrita_pendente} !== {exp_pulso, exp_inicio, exp_pend}) begin
        errors++;
        $display("FAIL bound_model k=%0d got %b/%b/%b required %b/%b/%b", k,
                 pulso, inicio_periodo, escrita_pendente, exp_pulso, exp_inicio, exp_pend);
      end
      checks++;
      if (pulso[3:1] !== 3'b010 || inicio_periodo[3] !== 1'b0) begin
        errors++;
        $display("FAIL bound_const k=%0d got pulso=%b inicio=%b required pulso[3:1]=010 inicio[3]=0",
                 k, pulso, inicio_periodo);
      end
    end
  endtask

  task automatic test_global_disable();
    aplica_reset();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b1111;
    for (int k = 0; k < 7; k++) avanca();
    habilitar_contagem = 1'b0;
    avanca();
    checks++;
    if (pulso !== 4'b0000 || inicio_periodo !== 4'b0000) begin
      errors++;
      $display("FAIL disable got pulso=%b inicio=%b required 0", pulso, inicio_periodo);
    end
    avanca();
    habilitar_contagem = 1'b1;
    for (int k = 0; k < 12; k++) begin
      avanca();
      checks++;
      if (pulso !== {4{(k % 10) < 5}} || inicio_periodo !== {4{(k % 10) == 0}}) begin
        errors++;
        $display("FAIL reenable_phase k=%0d got pulso=%b inicio=%b", k, pulso, inicio_periodo);
      end
    end
  endtask

  task automatic test_async_reset();
    aplica_reset();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b1111;
    for (int k = 0; k < 3; k++) avanca();
    escrever = 1'b1; canal_escrita = 2'd1; periodo_in = 8'd4; razao_in = 8'd2;
    avanca();
    escrever = 1'b0;
    avanca();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pulso, inicio_periodo, escrita_pendente} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got %b required 0", {pulso, inicio_periodo, escrita_pendente});
    end
    modelo_reset();
    avanca();
    reset = 1'b0;
    for (int k = 0; k < 21; k++) begin
      avanca();
      checks++;
      if (pulso !== {4{(k % 10) < 5}} || escrita_pendente !== 4'b0000 ||
          {pulso, inicio_periodo} !== {exp_pulso, exp_inicio}) begin
        errors++;
        $display("FAIL after_reset k=%0d got pulso=%b inicio=%b pend=%b", k, pulso, inicio_periodo,
                 escrita_pendente);
      end
    end
  endtask

  task automatic test_out_of_range();
    aplica_reset();
    habilitar_contagem = 1'b1; habilitar_canal = 4'b1111;
    esc3 = 1'b1; canal3 = 2'd3;
    for (int k = 0; k < 25; k++) begin
      per3 = 8'($urandom_range(0, 9)); raz3 = 8'($urandom_range(0, 12));
      avanca();
      checks++;
      if (pulso3 !== {3{(k % 10) < 5}} || inicio3 !== {3{(k % 10) == 0}} || pend3 !== 3'b000) begin
        errors++;
        $display("FAIL write_idx3 k=%0d got pulso=%b inicio=%b pend=%b", k, pulso3, inicio3, pend3);
      end
    end
    esc3 = 1'b0;
  endtask

  task automatic test_random();
    aplica_reset();
    for (int k = 0; k < 400; k++) begin
      habilitar_contagem = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) habilitar_canal = 4'($urandom);
      escrever = ($urandom_range(0, 5) == 0);
      canal_escrita = 2'($urandom);
      periodo_in = 8'($urandom_range(0, 14));
      razao_in = 8'($urandom_range(0, 16));
      if (escrever) $display("write ch%0d periodo=%0d razao=%0d", canal_escrita, periodo_in, razao_in);
      avanca();
      checks++;
      if ({pulso, inicio_periodo, escrita_pendente} !== {exp_pulso, exp_inicio, exp_pend}) begin
        errors++;
        $display("FAIL random k=%0d got %b/%b/%b required %b/%b/%b", k,
                 pulso, inicio_periodo, escrita_pendente, exp_pulso, exp_inicio, exp_pend);
      end
    end
    escrever = 1'b0;
  endtask

  initial begin
    reset = 1'b1; habilitar_contagem = 1'b0; habilitar_canal = '0;
    escrever = 1'b0; canal_escrita = '0; periodo_in = '0; razao_in = '0;
    esc3 = 1'b0; canal3 = '0; per3 = '0; raz3 = '0;
    modelo_reset();
    test_reset();
    test_default();
    test_shadow();
    test_boundaries();
    test_global_disable();
    test_async_reset();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
